// File: rtl/tube_scan.sv
// tube_scan: time-multiplexed 8-digit seven-segment scan driver.
// Scans eight shadowed segment codes onto one shared segment bus with a
// one-hot digit select. New codes/masks are taken only at frame boundaries,
// each digit slot starts with a dark gap, and digits can be masked or blinked.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   l0..l7              per-digit segment codes, l0 = rightmost digit
//   en_mask             per-digit enable
//   blink_mask          per-digit blink enable
//   upd                 one-cycle request to take new l0..l7 / masks
//   seg_out             shared segment bus (registered)
//   tube_sel            digit select, one-hot or zero (registered)
//   frame_done          pulse on the last cycle of each frame (registered)
module tube_scan #(
  parameter int unsigned TUBE_BITS    = 8,
  parameter int unsigned DIV          = 100000,
  parameter int unsigned BLANK_CYC    = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TUBE_BITS-1:0] l0,
  input  logic [TUBE_BITS-1:0] l1,
  input  logic [TUBE_BITS-1:0] l2,
  input  logic [TUBE_BITS-1:0] l3,
  input  logic [TUBE_BITS-1:0] l4,
  input  logic [TUBE_BITS-1:0] l5,
  input  logic [TUBE_BITS-1:0] l6,
  input  logic [TUBE_BITS-1:0] l7,
  input  logic [7:0]           en_mask,
  input  logic [7:0]           blink_mask,
  input  logic                 upd,
  output logic [TUBE_BITS-1:0] seg_out,
  output logic [7:0]           tube_sel,
  output logic                 frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [FW-1:0]        r_fcnt;
  logic                 r_bph;
  logic                 r_pend;
  logic [TUBE_BITS-1:0] r_sh_l [8];
  logic [7:0]           r_sh_en;
  logic [7:0]           r_sh_blink;

  logic [CW-1:0]        w_ncnt;
  logic [2:0]           w_nidx;
  logic                 w_slot_end;
  logic                 w_boundary;
  logic                 w_nboundary;
  logic                 w_nlit;
  logic [TUBE_BITS-1:0] w_l [8];

  // Gather the digit inputs so the shadow load can be a loop.
  always_comb begin
    w_l[0] = l0;
    w_l[1] = l1;
    w_l[2] = l2;
    w_l[3] = l3;
    w_l[4] = l4;
    w_l[5] = l5;
    w_l[6] = l6;
    w_l[7] = l7;
  end

  // Next scan position; outputs are registered from it so they line up
  // with the position counters on every cycle.
  always_comb begin
    w_slot_end  = (r_cnt == CW'(DIV - 1));
    w_ncnt      = w_slot_end ? '0 : r_cnt + CW'(1);
    w_nidx      = w_slot_end ? r_idx + 3'd1 : r_idx;
    w_boundary  = w_slot_end && (r_idx == 3'd7);
    w_nboundary = (w_ncnt == CW'(DIV - 1)) && (w_nidx == 3'd7);
    // The boundary edge always enters a blank cycle, so using the pre-load
    // shadow and blink phase here is never observable.
    w_nlit      = (w_ncnt >= CW'(BLANK_CYC)) && r_sh_en[w_nidx] &&
                  !(r_sh_blink[w_nidx] && r_bph);
  end

  // Scan counters, shadow/pending handling, blink phase and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_fcnt     <= '0;
      r_bph      <= 1'b0;
      r_pend     <= 1'b0;
      r_sh_en    <= '0;
      r_sh_blink <= '0;
      for (int i = 0; i < 8; i++) r_sh_l[i] <= '0;
      seg_out    <= '0;
      tube_sel   <= '0;
      frame_done <= 1'b0;
    end else begin
      r_cnt <= w_ncnt;
      r_idx <= w_nidx;

      if (w_boundary) begin
        // A request on the boundary cycle itself is honoured immediately.
        if (r_pend || upd) begin
          for (int i = 0; i < 8; i++) r_sh_l[i] <= w_l[i];
          r_sh_en    <= en_mask;
          r_sh_blink <= blink_mask;
        end
        r_pend <= 1'b0;
        if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
          r_fcnt <= '0;
          r_bph  <= ~r_bph;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end else if (upd) begin
        r_pend <= 1'b1;
      end

      frame_done <= w_nboundary;
      if (w_nlit) begin
        tube_sel <= 8'(1) << w_nidx;
        seg_out  <= r_sh_l[w_nidx];
      end else begin
        tube_sel <= '0;
        seg_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tube_scan.sv
// Self-checking bench for tube_scan with a frame-level reference model.
module tb_tube_scan;

  localparam int unsigned TB_BITS  = 8;
  localparam int unsigned TB_DIV   = 4;
  localparam int unsigned TB_BLANK = 1;
  localparam int unsigned TB_BF    = 2;
  localparam int unsigned FRAME    = 8 * TB_DIV;

  logic               clk;
  logic               rst_n;
  logic [TB_BITS-1:0] d_l [8];
  logic [7:0]         en_mask;
  logic [7:0]         blink_mask;
  logic               upd;
  logic [TB_BITS-1:0] seg_out;
  logic [7:0]         tube_sel;
  logic               frame_done;

  tube_scan #(
    .TUBE_BITS   (TB_BITS),
    .DIV         (TB_DIV),
    .BLANK_CYC   (TB_BLANK),
    .BLINK_FRAMES(TB_BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l0        (d_l[0]),
    .l1        (d_l[1]),
    .l2        (d_l[2]),
    .l3        (d_l[3]),
    .l4        (d_l[4]),
    .l5        (d_l[5]),
    .l6        (d_l[6]),
    .l7        (d_l[7]),
    .en_mask   (en_mask),
    .blink_mask(blink_mask),
    .upd       (upd),
    .seg_out   (seg_out),
    .tube_sel  (tube_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: cycles since reset plus the contents shown this frame.
  int               t;
  logic [TB_BITS-1:0] m_sh_l [8];
  logic [7:0]       m_sh_en;
  logic [7:0]       m_sh_blink;
  bit               m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    m_pend     = 0;
    m_sh_en    = '0;
    m_sh_blink = '0;
    for (int i = 0; i < 8; i++) m_sh_l[i] = '0;
  endtask

  // Expected outputs for cycle t, straight from the scan rules.
  task automatic expected(output logic [7:0] e_sel, output logic [TB_BITS-1:0] e_seg,
                          output logic e_fd);
    int pos, idx, k, f;
    bit bph, vis;
    pos = t % FRAME;
    idx = pos / TB_DIV;
    k   = pos % TB_DIV;
    f   = t / FRAME;
    bph = ((f / TB_BF) % 2) == 1;
    vis = m_sh_en[idx] && !(m_sh_blink[idx] && bph);
    e_sel = '0;
    e_seg = '0;
    if (k >= TB_BLANK && vis) begin
      e_sel[idx] = 1'b1;
      e_seg      = m_sh_l[idx];
    end
    e_fd = (pos == FRAME - 1);
  endtask

  // Drive upd for the current cycle, check outputs, advance one clock.
  task automatic step(input bit do_upd);
    logic [7:0] e_sel;
    logic [TB_BITS-1:0] e_seg;
    logic e_fd;
    upd = do_upd;
    expected(e_sel, e_seg, e_fd);
    check_eq("tube_sel", 32'(tube_sel), 32'(e_sel));
    check_eq("seg_out", 32'(seg_out), 32'(e_seg));
    check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    if (do_upd) m_pend = 1;
    if ((t % FRAME) == FRAME - 1) begin
      if (m_pend) begin
        for (int i = 0; i < 8; i++) m_sh_l[i] = d_l[i];
        m_sh_en    = en_mask;
        m_sh_blink = blink_mask;
      end
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'($urandom);
    en_mask    = 8'($urandom);
    blink_mask = 8'($urandom);
  endtask

  task automatic run_to(input int pos);
    while ((t % FRAME) != pos) step(1'b0);
  endtask

  // Request an update now and hold the inputs until it is taken.
  task automatic load(input logic [7:0] en, input logic [7:0] bl);
    en_mask    = en;
    blink_mask = bl;
    step(1'b1);
    while ((t % FRAME) != 0) step(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    upd    = 1'b0;
    rand_inputs();
    do_reset();

    // Dark after reset; basic scan with upd at cycle 5.
    repeat (5) step(1'b0);
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'(i + 1);
    load(8'hFF, 8'h00);
    repeat (FRAME) step(1'b0);
    // Input changes without upd are ignored.
    repeat (FRAME) begin rand_inputs(); step(1'b0); end

    // Tear-free: update l3 during digit 2; frame in progress unchanged.
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'(i + 1);
    run_to(2 * TB_DIV);
    d_l[3] = 8'h7F;
    load(8'hFF, 8'h00);
    repeat (FRAME) step(1'b0);

    // upd coincident with frame_done; pend must not linger afterwards.
    run_to(FRAME - 1);
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'(8'h10 + i);
    en_mask    = 8'hFF;
    blink_mask = 8'h00;
    step(1'b1);
    repeat (2 * FRAME) begin rand_inputs(); step(1'b0); end

    // Enable mask: digits 4..7 dark.
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'($urandom);
    load(8'h0F, 8'h00);
    repeat (2 * FRAME) step(1'b0);

    // Blink digit 0.
    load(8'hFF, 8'h01);
    repeat (6 * FRAME) step(1'b0);

    // Randomized traffic with sparse updates.
    repeat (40 * FRAME) begin
      rand_inputs();
      step($urandom_range(0, 15) == 0);
    end

    // Reset in the lit part of digit 3 blanks outputs with no clock edge.
    for (int i = 0; i < 8; i++) d_l[i] = TB_BITS'(8'h20 + i);
    load(8'hFF, 8'h00);
    run_to(3 * TB_DIV + 2);
    check_eq("pre_rst_sel", 32'(tube_sel), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_sel", 32'(tube_sel), 32'h0);
    check_eq("rst_async_seg", 32'(seg_out), 32'h0);
    check_eq("rst_async_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2 * FRAME) begin rand_inputs(); step(1'b0); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tube_scan.md
# tube_scan

Time-multiplexed 8-digit seven-segment scan driver. It sits directly downstream of the binary-to-digit decomposer and takes its eight per-digit segment codes l0..l7. It drives one shared segment bus plus eight digit-select lines, so every digit appears continuously lit. Frame-synchronous shadow loading prevents tearing, a programmable dark gap between digits suppresses ghosting, and per-digit enable and blink are supported.

## Interface
- TUBE_BITS, 8, width of one segment code (matches the codebase `TUBE_BITS`)
- DIV, 100000, clock cycles per digit slot (1 kHz slot at 100 MHz); must be ≥ 2
- BLANK_CYC, 1000, dark cycles at the start of each slot; 1 ≤ BLANK_CYC < DIV
- BLINK_FRAMES, 64, frames per blink half-period; must be ≥ 1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- l0..l7  in  TUBE_BITS each  segment code per digit, from the decomposer; l0 is the least significant/rightmost digit
- en_mask  in  8  bit i=1 enables digit i
- blink_mask  in  8  bit i=1 makes digit i blink
- upd  in  1  one-cycle request to take new l0..l7/en_mask/blink_mask
- seg_out  out  TUBE_BITS  shared segment bus
- tube_sel  out  8  digit select, one-hot or zero, active high
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Counters:
  - slot counter cnt runs 0..DIV-1, then wraps to 0.
  - When cnt wraps, digit index idx advances 0..7, then wraps to 0.
  - Frame = 8*DIV cycles.
- Shadow registers: sh_l0..sh_l7, sh_en, sh_blink.
- Pending flag pend: set by upd=1; cleared when the shadow loads.
- Frame boundary = the cycle with idx=7 and cnt=DIV-1.
  - At the boundary, if pend or upd is 1, the shadow captures the current inputs and pend clears.
  - upd coincident with the boundary loads at that same boundary.
  - upd during a frame never alters the frame in progress.
- Blink phase bph toggles after every BLINK_FRAMES completed frames; a frame counter counts 0..BLINK_FRAMES-1.
- Digit i is visible when sh_en[i]=1 and not (sh_blink[i]=1 and bph=1).
- Output per slot, with k = cnt:
  - k < BLANK_CYC: tube_sel=0, seg_out=0.
  - k ≥ BLANK_CYC and digit idx visible: tube_sel=1<<idx, seg_out=sh_l(idx).
  - k ≥ BLANK_CYC and digit idx not visible: tube_sel=0, seg_out=0.
- seg_out is always 0 whenever tube_sel is 0.
- tube_sel never has more than one bit set.
- frame_done=1 exactly on boundary cycles.
- Reset (async, rst_n=0):
  - Forced immediately: cnt=0, idx=0, pend=0, bph=0, frame counter=0, all shadows=0, seg_out=0, tube_sel=0, frame_done=0.
  - Because sh_en resets to 0, the display stays dark until the first upd has been applied at a frame boundary.
  - Reset mid-frame discards any pending update.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- The cycle after rst_n rises is slot cycle cnt=0 of digit 0.
- Outputs for slot position (idx, cnt) appear on the cycle labelled (idx, cnt); i.e. the output registers are fed from next-state cnt/idx.
- Shadow values captured at a boundary are first visible in digit 0 of the next frame, at cnt=BLANK_CYC.
- Worst-case update latency: upd at frame cycle 0 → visible after 8*DIV + BLANK_CYC cycles.
- bph toggles on the same edge that ends the BLINK_FRAMES-th frame; the new phase applies from digit 0 of the next frame.
- Input changes without upd have no effect.

## Test plan
All scenarios use DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
- Reset mid-slot:
  - Stimulus: assert rst_n=0 at idx=3, cnt=2.
  - Response: tube_sel=0 and seg_out=0 within the same cycle, with no clock edge needed. After release, frame_done pulses first at cycle 31, and nothing is lit because sh_en=0.
- Basic scan:
  - Stimulus: l0..l7=0x01..0x08, en_mask=0xFF, blink_mask=0, pulse upd at cycle 5.
  - Response: shadow loads at cycle 31. In the next frame, digit i shows 1 dark cycle, then 3 cycles of tube_sel=1<<i and seg_out=i+1.
- Tear-free update:
  - Stimulus: with the display running, set l3=0x7F and pulse upd during digit 2 of frame n.
  - Response: digit 3 still shows 0x04 in frame n and shows 0x7F from frame n+1.
- upd on the boundary:
  - Stimulus: pulse upd on the same cycle as frame_done.
  - Response: new values are visible in the very next frame, and pend is 0 afterwards.
- Enable mask:
  - Stimulus: en_mask=0x0F, then upd.
  - Response: tube_sel bits 4-7 are never set; slots 4-7 are fully dark with seg_out=0.
- Blink:
  - Stimulus: blink_mask=0x01, en_mask=0xFF, then upd.
  - Response: digit 0 is lit in 2 frames, dark in 2 frames, and the pattern repeats. Other digits are lit every frame.
